// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types, constants and helpers for the instruction memory loader
// Contents:
//   state_e   : loader FSM states
//   HDR_BYTES : bytes per header / per data word
//   cap_words : instruction memory capacity in words for a given byte-address width
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int HDR_BYTES = 4;

    function automatic logic [31:0] cap_words(input int addr_width);
        return 32'd1 << (addr_width - 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs accepted stream bytes into little-endian 32-bit words
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : drop any partially assembled word (session start)
//   accept_i      : a byte is transferred this cycle
//   byte_i        : the byte being transferred
//   word_valid_o  : high in the cycle the 4th byte of a word is transferred
//   word_o        : the completed word, valid while word_valid_o is high
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        last_byte;

    assign last_byte = (cnt_q == 2'(HDR_BYTES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            // Bytes enter at the top and move down, so the first byte ends in [7:0].
            shreg_d = {byte_i, shreg_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shreg_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Completed word is presented combinationally in the cycle of the 4th byte so the
    // top level can register the memory write on that same edge.
    assign word_valid_o = accept_i && last_byte;
    assign word_o       = {byte_i, shreg_q[31:8]};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader writing instruction memory from a length-prefixed byte stream
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start_i            : pulse that begins a load session (honoured in IDLE/DONE/ERROR)
//   byte_valid_i/data_i: byte stream input, byte_ready_o is the matching ready
//   wr_en_o/addr_o/data_o : instruction memory write port (byte address, word aligned)
//   cpu_hold_o         : holds the core in reset until a load completes
//   done_o / error_o   : load finished / header length exceeded capacity
//   words_loaded_o     : words written in the current session
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-2:0] words_loaded_o
);

    localparam int          CNT_W = ADDR_WIDTH - 1;
    localparam logic [31:0] CAP   = cap_words(ADDR_WIDTH);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       n_q;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   hold_q;
    logic                   done_q;
    logic                   error_q;

    logic        accept;
    logic        start_ok;
    logic        word_valid;
    logic [31:0] word;

    assign byte_ready_o = (state_q == ST_LEN) || (state_q == ST_LOAD);
    assign accept       = byte_valid_i && byte_ready_o;
    assign start_ok     = start_i &&
                          ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));

    // One assembler serves both the header and the data words; it is idle between them
    // only when a word boundary has been reached, so its counter is already at zero.
    byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok),
        .accept_i     (accept),
        .byte_i       (byte_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            n_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        state_q <= ST_LEN;
                        addr_q  <= '0;
                        count_q <= '0;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (word_valid) begin
                        // Full 32-bit compare so large headers cannot alias to a small length.
                        if (word > CAP) begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (word == 32'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            n_q     <= word[CNT_W-1:0];
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= word;
                        addr_q    <= addr_q + ADDR_WIDTH'(4);
                        count_q   <= count_q + CNT_W'(1);
                        if (count_q + CNT_W'(1) == n_q) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Final write is on the bus this cycle; release the core only afterwards.
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign cpu_hold_o     = hold_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a queue-based write model
module tb_imem_loader;

    localparam int AW  = 10;
    localparam int CAP = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = 8'd0;
    logic          byte_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [31:0]   wr_data_o;
    logic          cpu_hold_o;
    logic          done_o;
    logic          error_o;
    logic [AW-2:0] words_loaded_o;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] mon_addr[$];
    logic [31:0]   mon_data[$];
    logic [31:0]   exp_words[$];

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .byte_valid_i   (byte_valid_i),
        .byte_data_i    (byte_data_i),
        .byte_ready_o   (byte_ready_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .cpu_hold_o     (cpu_hold_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    // Record every memory write; expected contents are word k at byte address 4k.
    always @(negedge clk) begin
        if (wr_en_o) begin
            mon_addr.push_back(wr_addr_o);
            mon_data.push_back(wr_data_o);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_model();
        mon_addr.delete();
        mon_data.delete();
        exp_words.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte has been taken.
    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit with_start);
        int gap;
        bit acc;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        start_i      = with_start;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = byte_ready_o;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        byte_valid_i = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_byte_timeout got=ready_low exp=accept");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input int start_at);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap, i == start_at);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", byte_ready_o); end
        total++; if (wr_en_o !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b exp=0", wr_en_o); end
        total++; if (wr_addr_o !== '0 || wr_data_o !== '0) begin bad++; $display("FAIL rst_wr_bus got=%0h/%0h exp=0/0", wr_addr_o, wr_data_o); end
        total++; if (cpu_hold_o !== 1'b1) begin bad++; $display("FAIL rst_hold got=%0b exp=1", cpu_hold_o); end
        total++; if (done_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b exp=00", done_o, error_o); end
        total++; if (words_loaded_o !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", words_loaded_o); end
    endtask

    task automatic test_basic();
        clear_model();
        exp_words.push_back(32'h00500093);
        exp_words.push_back(32'h00100113);
        repeat (2) @(posedge clk); #1;
        total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL idle_ready got=%0b exp=0", byte_ready_o); end
        pulse_start();
        total++; if (byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin bad++; $display("FAIL len_ready_hold got=%0b%0b exp=11", byte_ready_o, cpu_hold_o); end
        send_word(32'd2, 0, -1);
        send_word(exp_words[0], 0, -1);
        total++; if (wr_en_o !== 1'b1 || wr_addr_o !== 10'h000 || wr_data_o !== exp_words[0]) begin bad++; $display("FAIL basic_w0 got=%0b@%0h:%0h exp=1@0:%0h", wr_en_o, wr_addr_o, wr_data_o, exp_words[0]); end
        send_word(exp_words[1], 0, -1);
        total++; if (wr_en_o !== 1'b1 || wr_addr_o !== 10'h004 || done_o !== 1'b0) begin bad++; $display("FAIL basic_w1 got=%0b@%0h done=%0b exp=1@4 done=0", wr_en_o, wr_addr_o, done_o); end
        total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", byte_ready_o); end
        @(posedge clk); #1;
        total++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0 || wr_en_o !== 1'b0) begin bad++; $display("FAIL basic_done got=done%0b hold%0b wr%0b exp=done1 hold0 wr0", done_o, cpu_hold_o, wr_en_o); end
        total++; if (words_loaded_o !== 9'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", words_loaded_o); end
        total++; if (mon_data.size() != 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", mon_data.size()); end
        else foreach (exp_words[k]) begin
            total++; if (mon_addr[k] !== AW'(4*k) || mon_data[k] !== exp_words[k]) begin bad++; $display("FAIL basic_write%0d got=%0h:%0h exp=%0h:%0h", k, mon_addr[k], mon_data[k], 4*k, exp_words[k]); end
        end
    endtask

    task automatic test_zero();
        clear_model();
        pulse_start();
        send_word(32'd0, 1, 2);
        total++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0) begin bad++; $display("FAIL zero_done got=done%0b hold%0b exp=done1 hold0", done_o, cpu_hold_o); end
        total++; if (words_loaded_o !== '0) begin bad++; $display("FAIL zero_count got=%0d exp=0", words_loaded_o); end
        repeat (3) @(posedge clk); #1;
        total++; if (mon_data.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", mon_data.size()); end
    endtask

    task automatic test_error();
        logic [31:0] hdrs [2];
        hdrs[0] = 32'd257;
        hdrs[1] = 32'h0001_0001;
        foreach (hdrs[h]) begin
            clear_model();
            pulse_start();
            total++; if (error_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL err_clear%0d got=err%0b done%0b exp=00", h, error_o, done_o); end
            send_word(hdrs[h], 0, -1);
            total++; if (error_o !== 1'b1 || byte_ready_o !== 1'b0 || cpu_hold_o !== 1'b1) begin bad++; $display("FAIL err_state%0d got=err%0b rdy%0b hold%0b exp=err1 rdy0 hold1", h, error_o, byte_ready_o, cpu_hold_o); end
            repeat (4) @(posedge clk); #1;
            total++; if (mon_data.size() != 0 || cpu_hold_o !== 1'b1) begin bad++; $display("FAIL err_nowrite%0d got=%0d hold%0b exp=0 hold1", h, mon_data.size(), cpu_hold_o); end
        end
    endtask

    task automatic test_gaps();
        clear_model();
        for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
        pulse_start();
        send_word(32'd3, 3, 1);
        send_word(exp_words[0], 3, -1);
        send_word(exp_words[1], 3, 2);
        send_word(exp_words[2], 3, -1);
        total++; if (wr_en_o !== 1'b1 || wr_addr_o !== 10'h008) begin bad++; $display("FAIL gaps_last got=%0b@%0h exp=1@8", wr_en_o, wr_addr_o); end
        @(posedge clk); #1;
        total++; if (done_o !== 1'b1 || words_loaded_o !== 9'd3) begin bad++; $display("FAIL gaps_done got=done%0b n%0d exp=done1 n3", done_o, words_loaded_o); end
        total++; if (mon_data.size() != 3) begin bad++; $display("FAIL gaps_nwrites got=%0d exp=3", mon_data.size()); end
        else foreach (exp_words[k]) begin
            total++; if (mon_addr[k] !== AW'(4*k) || mon_data[k] !== exp_words[k]) begin bad++; $display("FAIL gaps_write%0d got=%0h:%0h exp=%0h:%0h", k, mon_addr[k], mon_data[k], 4*k, exp_words[k]); end
        end
    endtask

    task automatic test_capacity();
        int mism;
        clear_model();
        for (int i = 0; i < CAP; i++) exp_words.push_back($urandom);
        pulse_start();
        send_word(32'(CAP), 0, -1);
        foreach (exp_words[k]) send_word(exp_words[k], 0, -1);
        @(posedge clk); #1;
        total++; if (done_o !== 1'b1 || error_o !== 1'b0 || words_loaded_o !== 9'd256) begin bad++; $display("FAIL cap_done got=done%0b err%0b n%0d exp=done1 err0 n256", done_o, error_o, words_loaded_o); end
        total++; if (mon_data.size() != CAP) begin bad++; $display("FAIL cap_nwrites got=%0d exp=%0d", mon_data.size(), CAP); end
        else begin
            mism = 0;
            foreach (exp_words[k]) if (mon_addr[k] !== AW'(4*k) || mon_data[k] !== exp_words[k]) mism++;
            total++; if (mism != 0 || mon_addr[CAP-1] !== 10'h3FC) begin bad++; $display("FAIL cap_writes got=%0d_bad last=%0h exp=0_bad last=3fc", mism, mon_addr[CAP-1]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        clear_model();
        pulse_start();
        send_word(32'd4, 0, -1);
        send_word($urandom | 32'h1, 0, -1);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (wr_en_o !== 1'b0 || wr_addr_o !== '0 || wr_data_o !== '0) begin bad++; $display("FAIL mid_rst_bus got=%0b@%0h:%0h exp=0@0:0", wr_en_o, wr_addr_o, wr_data_o); end
        total++; if (byte_ready_o !== 1'b0 || cpu_hold_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=rdy%0b hold%0b done%0b err%0b exp=0100", byte_ready_o, cpu_hold_o, done_o, error_o); end
        total++; if (words_loaded_o !== '0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", words_loaded_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        w = $urandom;
        exp_words.push_back(w);
        pulse_start();
        send_word(32'd1, 0, -1);
        send_word(w, 0, -1);
        @(posedge clk); #1;
        total++; if (mon_data.size() != 1 || mon_addr[0] !== '0 || mon_data[0] !== w) begin bad++; $display("FAIL mid_reload got=%0d writes exp=1 write %0h@0", mon_data.size(), w); end
    endtask

    task automatic test_restart();
        logic [31:0] w;
        clear_model();
        w = $urandom;
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL rs_pre got=%0b exp=1", done_o); end
        pulse_start();
        total++; if (done_o !== 1'b0 || cpu_hold_o !== 1'b1 || words_loaded_o !== '0) begin bad++; $display("FAIL rs_start got=done%0b hold%0b n%0d exp=done0 hold1 n0", done_o, cpu_hold_o, words_loaded_o); end
        send_word(32'd1, 2, -1);
        send_word(w, 2, -1);
        total++; if (wr_en_o !== 1'b1 || wr_addr_o !== '0 || wr_data_o !== w || done_o !== 1'b0) begin bad++; $display("FAIL rs_write got=%0b@%0h:%0h done%0b exp=1@0:%0h done0", wr_en_o, wr_addr_o, wr_data_o, done_o, w); end
        @(posedge clk); #1;
        total++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0 || words_loaded_o !== 9'd1) begin bad++; $display("FAIL rs_done got=done%0b hold%0b n%0d exp=done1 hold0 n1", done_o, cpu_hold_o, words_loaded_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_zero();
        test_error();
        test_gaps();
        test_capacity();
        test_reset_mid();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream instead of a pre-initialised image. It accepts bytes over a valid/ready handshake, assembles little-endian 32-bit words, and drives the instruction memory's write port at word-aligned byte addresses. It holds the core in reset until the whole program is written.

## Interface
- `ADDR_WIDTH`, 10: byte-address width of the instruction memory. Capacity is `CAP = 2^(ADDR_WIDTH-2)` words.
- `DATA_WIDTH`, 32: instruction word width. Fixed at 32; other values are unsupported.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: one-cycle pulse that begins a load session.
- `byte_valid_i`  in  1: a byte is presented on `byte_data_i`.
- `byte_data_i`  in  8: stream byte.
- `byte_ready_o`  out  1: loader accepts a byte this cycle.
- `wr_en_o`  out  1: instruction memory write strobe, one cycle per word.
- `wr_addr_o`  out  ADDR_WIDTH: byte address; bits [1:0] are always 0.
- `wr_data_o`  out  32: word to write.
- `cpu_hold_o`  out  1: keeps the core in reset while asserted.
- `done_o`  out  1: load completed successfully.
- `error_o`  out  1: length header exceeded `CAP`.
- `words_loaded_o`  out  ADDR_WIDTH-1: number of words written in this session.

## Operation
- A byte is accepted on an edge where `byte_valid_i && byte_ready_o`. When `byte_ready_o` is 0, `byte_valid_i` is ignored.
- Stream format is a 4-byte header N (number of words), followed by N words. All fields are little-endian: the first byte goes to bits [7:0].
- States:
  - IDLE: `byte_ready_o`=0. On `start_i`, go to LEN.
  - LEN: `byte_ready_o`=1. On the 4th accepted byte:
    - N > `CAP`: go to ERROR.
    - N == 0: go to DONE.
    - Otherwise: go to LOAD.
  - LOAD: `byte_ready_o`=1. On the 4th byte of each word, issue a write. After the write of word N-1 is issued, go to FLUSH.
  - FLUSH: `byte_ready_o`=0. Lasts one cycle, then go to DONE.
  - DONE: `done_o`=1, `cpu_hold_o`=0, `byte_ready_o`=0.
  - ERROR: `error_o`=1, `cpu_hold_o`=1, `byte_ready_o`=0.
- `start_i` is honoured in IDLE, DONE and ERROR. It is ignored in LEN, LOAD and FLUSH.
  - Start from DONE or ERROR: clears `done_o`, `error_o` and `words_loaded_o`, sets `cpu_hold_o`=1, and enters LEN.
- Word k is written to byte address 4k. The address increments by 4 per word. Wrap-around cannot occur because N ≤ `CAP`.
- Header comparison uses the full 32-bit N; upper bits are not truncated.
- Reset mid-session returns every register to its reset value. Memory contents already written are left as they are.

## Timing
- Reset values: state IDLE, `byte_ready_o`=0, `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `cpu_hold_o`=1, `done_o`=0, `error_o`=0, `words_loaded_o`=0.
- All outputs are registered except `byte_ready_o`, which is decoded from the state.
- Write latency:
  - The edge that accepts a word's 4th byte makes `wr_en_o`=1 for exactly the following cycle, with the matching `wr_addr_o` and `wr_data_o`.
  - `words_loaded_o` increments on that same edge.
- Sustained throughput is one byte per cycle with no bubbles, and one write every 4 cycles. Gaps in `byte_valid_i` stall assembly without losing bytes.
- `done_o` rises, and `cpu_hold_o` falls, on the edge after the cycle in which the final `wr_en_o` is high. The core therefore never fetches during a write.
- For N=0: `done_o` is 1 in the cycle after the 4th header byte.
- `start_i` in LEN: `start_i` in the same cycle as a byte acceptance does not disturb the byte.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum (IDLE, LEN, LOAD, FLUSH, DONE, ERROR);
  - `HDR_BYTES`=4;
  - a function returning `CAP` from `ADDR_WIDTH`.
- Sub-module `byte_assembler` contains:
  - a 2-bit byte counter and a 32-bit shift register;
  - a single-cycle `word_valid` pulse.
  It is reused for both the header and the data words.
- The top level holds the FSM, the address/count registers and the output registers.

## Test plan
- Stream header 2, then 0x00500093, 0x00100113, with no gaps. Expect:
  - `wr_en_o` pulses at addr 0x000 and 0x004 with those words;
  - `done_o`=1 one cycle after the 2nd pulse, with `cpu_hold_o`=0 and `words_loaded_o`=2.
- Header N=0 → no `wr_en_o`; `done_o`=1 the cycle after the 4th byte.
- Header N=257 with ADDR_WIDTH=10 → ERROR; `error_o`=1, `byte_ready_o`=0, `cpu_hold_o` stays 1, no writes.
- Load 3 words with random `byte_valid_i` gaps, plus a `start_i` pulse mid-LOAD → data and addresses identical to the gap-free run; `start_i` ignored.
- `rst_n` low after 1.5 words → all outputs at reset values asynchronously; a subsequent `start_i` reloads from addr 0.
- After DONE, pulse `start_i` and load 1 word → `done_o` drops, `cpu_hold_o`=1, then word written at addr 0 and `done_o` re-asserts.
